// File: rtl/param_ram_if.sv
// -----------------------------------------------------------------------------
// param_ram_if -- request/response bus for param_ram.
//
// Request channel (master -> slave):
//   req_valid    request present
//   req_ready    slave accepts a request this cycle (slave -> master)
//   req_write_n  0 = write, 1 = read
//   req_addr     word address
//   req_wdata    write data
//   req_be       byte enables, bit i qualifies bits [8i+7:8i]
// Response channel (slave -> master):
//   rsp_valid    read data valid
//   rsp_ready    master accepts the response (master -> slave)
//   rsp_rdata    read data
// -----------------------------------------------------------------------------
interface param_ram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BE_W   = DATA_W / 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write_n;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write_n, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write_n, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/param_ram.sv
// -----------------------------------------------------------------------------
// param_ram -- single-port word RAM with byte-lane writes and a registered,
// back-pressurable read response (latency 1).
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width, depth = 2**ADDR_W words
//   BE_W    byte-enable width, one bit per byte lane
//
// Ports:
//   clk   clock, all state changes on its rising edge
//   rst   synchronous active-high reset
//   bus   param_ram_if.slave request/response bus
//   busy  1 while the initialisation clear is running
//
// Build option:
//   RAM_INIT_CLEAR_EN  when defined, reset enters a CLEAR state that writes
//                      zero to every word, one per cycle, before accepting
//                      requests. When undefined, there is no clear logic,
//                      busy is tied low and memory starts undefined.
// -----------------------------------------------------------------------------
module param_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic        clk,
  input  logic        rst,
  param_ram_if.slave  bus,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = ST_CLEAR;
`else
  typedef enum logic {ST_RUN} state_t;
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              run;
  logic              busy_c;
  logic              req_ready_c;
  logic              fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              clr_we;

`ifdef RAM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    run         = 1'b0;
    busy_c      = 1'b0;
    clr_we      = 1'b0;
`ifdef RAM_INIT_CLEAR_EN
    case (state_q)
      ST_CLEAR: begin
        busy_c = 1'b1;
        clr_we = !rst;
        if (clr_addr_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
`else
    run = (state_q == ST_RUN);
`endif
    // rst gates ready combinationally so no request slips in while the
    // synchronous reset is still waiting for its edge.
    req_ready_c = run && !rst && !(rsp_valid_q && !bus.rsp_ready);
    fire        = bus.req_valid && req_ready_c;
    wr_fire     = fire && !bus.req_write_n;
    rd_fire     = fire &&  bus.req_write_n;
  end

`ifdef RAM_INIT_CLEAR_EN
  // ---------------------------------------------------------------------------
  // Clear address counter; wraps back to 0 on the transition to RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= clr_addr_q + ADDR_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Memory array: no reset, written by the clear sequence or byte-lane writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
`ifdef RAM_INIT_CLEAR_EN
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else
`endif
    if (wr_fire) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) begin
          mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response register. The read data is captured into its own register, so a
  // later write to the same word cannot disturb a response already issued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= mem[bus.req_addr];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_param_ram.sv
// -----------------------------------------------------------------------------
// tb_param_ram -- directed and randomised checks of param_ram (DATA_W=16,
// ADDR_W=4). Expected read data comes from a bench-side memory model and is
// queued on acceptance; a monitor pops and compares on each response handshake.
// -----------------------------------------------------------------------------
module tb_param_ram;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  param_ram_if #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) bus ();

  param_ram #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: compare on every handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected_rsp observed=0x%0h expected=no_response", bus.rsp_rdata);
      end else begin
        check("sb_rdata", bus.rsp_rdata, sb.pop_front());
      end
    end
  end

  // Drives one request from posedge+1 and returns at posedge+1 after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, output logic ok);
    bus.req_valid   = 1'b1;
    bus.req_write_n = ~wr;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    bus.req_be      = be;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL req_timeout observed=stalled expected=accepted addr=%0d", a);
    end
  endtask

  task automatic write_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic ok;
    issue(1'b1, a, d, be, ok);
    if (ok) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic read_w(input logic [AW-1:0] a);
    logic ok;
    logic [DW-1:0] exp;
    exp = model[a];
    issue(1'b0, a, '0, '0, ok);
    if (ok) begin
      sb.push_back(exp);
      check("rd_valid_lat1", bus.rsp_valid, 1);
      check("rd_data_lat1", bus.rsp_rdata, exp);
    end
  endtask

  initial begin
    int cnt;
    int bad;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [BW-1:0] rb;

    bus.req_valid   = 1'b0;
    bus.req_write_n = 1'b1;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_be      = '0;
    bus.rsp_ready   = 1'b1;
    rst             = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_req_ready", bus.req_ready, 0);

`ifdef RAM_INIT_CLEAR_EN
    check("rst_busy", busy, 1);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 8; c++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    check("clear_first8", cnt, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (bus.req_ready !== 1'b0) bad++;
    end
    check("clear_busy_cycles", cnt, 16);
    check("clear_ready_low", bad, 0);
    check("clear_done_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    read_w(4'd15);
    check("clear_addr15_zero", bus.rsp_rdata, 16'h0000);
`else
    rst = 1'b0;
    @(negedge clk);
    check("run_busy_low", busy, 0);
    check("run_ready_first", bus.req_ready, 1);
    @(posedge clk);
    #1;
`endif

    // Define every word so all later reads have known contents.
    for (int i = 0; i < DEPTH; i++) write_w(AW'(i), DW'(i * 16'h1111) ^ 16'h5A0F, 2'b11);

    // Byte-lane writes.
    write_w(4'd5, 16'hABCD, 2'b11);
    write_w(4'd5, 16'h1234, 2'b01);
    read_w(4'd5);
    check("lane_ab34", bus.rsp_rdata, 16'hAB34);
    write_w(4'd5, 16'hFFFF, 2'b00);
    read_w(4'd5);
    check("be_zero_nochange", bus.rsp_rdata, 16'hAB34);
    write_w(4'd5, 16'h9911, 2'b10);
    read_w(4'd5);
    check("lane_hi_only", bus.rsp_rdata, 16'h9934);

    // Read immediately after write to the same word.
    write_w(4'd3, 16'h00FF, 2'b11);
    read_w(4'd3);
    check("wr_then_rd", bus.rsp_rdata, 16'h00FF);

    // Back-to-back reads.
    read_w(4'd1);
    read_w(4'd2);
    @(posedge clk);
    #1;
    check("b2b_valid_drop", bus.rsp_valid, 0);

    // Backpressure hold.
    bus.rsp_ready = 1'b0;
    read_w(4'd7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_rdata", bus.rsp_rdata, model[7]);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    check("bp_consumed", bus.rsp_valid, 0);

    // Consume and accept a new read in the same cycle.
    bus.rsp_ready = 1'b0;
    read_w(4'd7);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    read_w(4'd8);
    // Write to the word just read while its response is being consumed.
    write_w(4'd8, 16'hDEAD, 2'b11);
    @(posedge clk);
    #1;

    // Randomised mix with occasional backpressure.
    for (int n = 0; n < 60; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.rsp_ready && bus.rsp_valid === 1'b1) begin
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom);
      rb = BW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) write_w(ra, rd, rb);
      else                           read_w(ra);
    end
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    // Reset with a response pending.
    bus.rsp_ready = 1'b0;
    read_w(4'd9);
    check("pend_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drop_valid", bus.rsp_valid, 0);
    check("rst_drop_rdata", bus.rsp_rdata, 0);
    check("rst_drop_ready", bus.req_ready, 0);
    sb.delete();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
`ifdef RAM_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    read_w(4'd9);
    repeat (2) @(posedge clk);
    #1;
    check("sb_final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
